// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the runtime-programmable serial pattern detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_detect_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam logic [DEF_MAX_LEN-1:0] DEF_PATTERN_C = 8'b0000_1011;
    localparam int DEF_LEN_C = 4;
    localparam bit DEF_OVERLAP_C = 1'b1;

    // Width able to hold every length from 0 to max_len inclusive.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    localparam int DEF_LEN_W = len_w(DEF_MAX_LEN);

    typedef struct packed {
        logic [DEF_MAX_LEN-1:0] pattern;
        logic [DEF_LEN_W-1:0]   len;
        logic                   overlap;
    } cfg_t;

endpackage

// File: rtl/seq_match_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
// Latency: count reflects an increment one edge after inc is sampled.
// Backpressure: none; every inc pulse is counted until saturation.
module seq_match_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector, overlapping or not; SEQ_DETECT_COUNT_EN adds a match counter.
// Latency: z is registered and high the cycle after the final pattern bit is presented.
// Backpressure: none; x_valid low stalls the shift without losing partial progress.
module seq_pattern_detector
    import seq_detect_pkg::*;
#(
    parameter int                 MAX_LEN     = DEF_MAX_LEN,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
    parameter int                 DEF_LEN     = DEF_LEN_C,
    parameter bit                 DEF_OVERLAP = DEF_OVERLAP_C,
    parameter int                 CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         x,
    input  logic                         x_valid,
    input  logic                         cfg_load,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    output logic                         z,
    output logic                         cfg_err,
    output logic [CNT_W-1:0]             match_cnt,
    input  logic                         cnt_clr
);

    localparam int LEN_W = len_w(MAX_LEN);

    typedef struct packed {
        logic [MAX_LEN-1:0] pattern;
        logic [LEN_W-1:0]   len;
        logic               overlap;
    } act_cfg_t;

    act_cfg_t           cfg_q;
    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_next;
    logic               accept;
    logic               hit;

    // Match is judged on the post-shift history so z lands on the same edge as the last bit.
    always_comb begin
        accept    = x_valid & ~cfg_load;
        hist_next = hist;
        fill_next = fill;
        if (accept) begin
            hist_next = {hist[MAX_LEN-2:0], x};
            if (fill != LEN_W'(MAX_LEN)) begin
                fill_next = fill + LEN_W'(1);
            end
        end
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < cfg_q.len);
        end
        hit = accept && !cfg_err && (fill_next >= cfg_q.len) &&
              (((hist_next ^ cfg_q.pattern) & len_mask) == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q   <= '{pattern: DEF_PATTERN, len: LEN_W'(DEF_LEN), overlap: DEF_OVERLAP};
            hist    <= '0;
            fill    <= '0;
            z       <= 1'b0;
            cfg_err <= 1'b0;
        end else if (cfg_load) begin
            cfg_q   <= '{pattern: cfg_pattern, len: cfg_len, overlap: cfg_overlap};
            hist    <= '0;
            fill    <= '0;
            z       <= 1'b0;
            cfg_err <= (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));
        end else begin
            hist <= hist_next;
            // Non-overlapping mode demands a full fresh pattern after each hit.
            fill <= (hit && !cfg_q.overlap) ? '0 : fill_next;
            z    <= hit;
        end
    end

`ifdef SEQ_DETECT_COUNT_EN
    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit),
        .clr   (cnt_clr),
        .cnt   (match_cnt)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = CNT_W'(0);
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector: expected z per driven cycle is queued, then compared.
module tb_seq_pattern_detector;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               x;
    logic               x_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               z;
    logic               cfg_err;
    logic [CNT_W-1:0]   match_cnt;

    int   total = 0;
    int   bad   = 0;
    logic exp_q[$];
    logic got_q[$];

    always #5 clk = ~clk;

    seq_pattern_detector #(
        .MAX_LEN     (MAX_LEN),
        .DEF_PATTERN (8'b0000_1011),
        .DEF_LEN     (4),
        .DEF_OVERLAP (1'b1),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x           (x),
        .x_valid     (x_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .z           (z),
        .cfg_err     (cfg_err),
        .match_cnt   (match_cnt),
        .cnt_clr     (cnt_clr)
    );

    task automatic drive(input logic xv, input logic xb, input logic ez, input logic ld);
        x_valid  = xv;
        x        = xb;
        cfg_load = ld;
        exp_q.push_back(ez);
        @(posedge clk);
        #1;
        got_q.push_back(z);
        x_valid  = 1'b0;
        cfg_load = 1'b0;
    endtask

    // Load drives a valid '1' too; it must be discarded.
    task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        drive(1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    // '1'/'0' present a valid bit, '-' is a stall cycle; ez gives expected z after each edge.
    task automatic feed(input string bits, input string ez);
        for (int i = 0; i < bits.len(); i++) begin
            drive(bits[i] != "-", bits[i] == "1", ez[i] == "1", 1'b0);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; x = 1'b0; x_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        #12;
        total++; if (z !== 1'b0) begin bad++; $display("FAIL reset_z z=%b expected=0", z); end
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err cfg_err=%b expected=0", cfg_err); end
        total++; if (match_cnt !== '0) begin bad++; $display("FAIL reset_cnt match_cnt=%0d expected=0", match_cnt); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_default_overlap();
        logic e, g;
        logic [CNT_W-1:0] want;
        int n = 0;
`ifdef SEQ_DETECT_COUNT_EN
        want = 2'd2;
`else
        want = 2'd0;
`endif
        feed("1011011", "0001001");
        total++; if (match_cnt !== want) begin bad++; $display("FAIL default_cnt match_cnt=%0d expected=%0d", match_cnt, want); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL default_z[%0d] z=%b expected=%b", n, g, e); end
            n++;
        end
    endtask

    task automatic test_non_overlap();
        logic e, g;
        int n = 0;
        load(8'h0B, 4'd4, 1'b0);
        feed("1011011", "0001000");
        load(8'h0B, 4'd4, 1'b0);
        feed("10111011", "00010001");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL nonovl_z[%0d] z=%b expected=%b", n, g, e); end
            n++;
        end
    endtask

    task automatic test_stall();
        logic e, g;
        int n = 0;
        load(8'h0B, 4'd4, 1'b0);
        feed("10---11-", "00000010");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL stall_z[%0d] z=%b expected=%b", n, g, e); end
            n++;
        end
    endtask

    task automatic test_len8();
        logic e, g;
        int n = 0;
        load(8'hA5, 4'd8, 1'b1);
        feed("1010010110100101", "0000000100000001");
        feed("10100", "00000");
        load(8'hA5, 4'd8, 1'b1);
        feed("10110100101", "00000000001");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL len8_z[%0d] z=%b expected=%b", n, g, e); end
            n++;
        end
    endtask

    task automatic test_illegal_and_reset();
        logic e, g;
        int n = 0;
        load(8'h0B, 4'd0, 1'b1);
        total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL err_len0 cfg_err=%b expected=1", cfg_err); end
        feed("10111011", "00000000");
        load(8'h0B, 4'd4, 1'b1);
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL err_clear cfg_err=%b expected=0", cfg_err); end
        feed("1011", "0001");
        load(8'h0B, 4'd9, 1'b1);
        total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL err_len9 cfg_err=%b expected=1", cfg_err); end
        feed("1011", "0000");
        pulse_reset();
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL err_after_rst cfg_err=%b expected=0", cfg_err); end
        feed("101", "000");
        pulse_reset();
        total++; if (z !== 1'b0) begin bad++; $display("FAIL rst_mid_z z=%b expected=0", z); end
        feed("1011", "0001");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL illegal_z[%0d] z=%b expected=%b", n, g, e); end
            n++;
        end
    endtask

    task automatic test_counter();
        logic e, g;
        logic [CNT_W-1:0] want_sat, want_one;
        int n = 0;
`ifdef SEQ_DETECT_COUNT_EN
        want_sat = 2'd3;
        want_one = 2'd1;
`else
        want_sat = 2'd0;
        want_one = 2'd0;
`endif
        pulse_reset();
        total++; if (match_cnt !== '0) begin bad++; $display("FAIL cnt_rst match_cnt=%0d expected=0", match_cnt); end
        feed("1011011011011011", "0001001001001001");
        total++; if (match_cnt !== want_sat) begin bad++; $display("FAIL cnt_sat match_cnt=%0d expected=%0d", match_cnt, want_sat); end
        feed("01", "00");
        cnt_clr = 1'b1;
        feed("1", "1");
        cnt_clr = 1'b0;
        total++; if (match_cnt !== '0) begin bad++; $display("FAIL cnt_clr_wins match_cnt=%0d expected=0", match_cnt); end
        load(8'h0F, 4'd4, 1'b1);
        total++; if (match_cnt !== '0) begin bad++; $display("FAIL cnt_load_keeps match_cnt=%0d expected=0", match_cnt); end
        feed("1111", "0001");
        total++; if (match_cnt !== want_one) begin bad++; $display("FAIL cnt_after_clr match_cnt=%0d expected=%0d", match_cnt, want_one); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL counter_z[%0d] z=%b expected=%b", n, g, e); end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_default_overlap();
        test_non_overlap();
        test_stall();
        test_len8();
        test_illegal_and_reset();
        test_counter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
Parametrised, runtime-programmable serial pattern detector; successor to the fixed 1011 Moore detector.
- Pattern and pattern length (1..MAX_LEN) are loaded at runtime.
- Overlapping or non-overlapping detection is selected at load time.
- Input is qualified by a valid strobe; the match output is registered (Moore-style).
- Used wherever a serial bitstream must be scanned for a sync word or marker.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
DEF_PATTERN, 8'b0000_1011, pattern after reset (MAX_LEN bits, right-aligned)
DEF_LEN, 4, pattern length after reset
DEF_OVERLAP, 1, overlap mode after reset (1 = overlapping)
CNT_W, 16, match counter width (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
x  in  1  serial input bit
x_valid  in  1  x is sampled only when high
cfg_load  in  1  one-cycle strobe; loads cfg_* and clears history
cfg_pattern  in  MAX_LEN  pattern; first-received bit at index cfg_len-1, last at index 0
cfg_len  in  $clog2(MAX_LEN+1)  pattern length
cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping
z  out  1  registered match pulse
cfg_err  out  1  loaded length is illegal (0 or >MAX_LEN); detector disabled
match_cnt  out  CNT_W  saturating match count (optional feature; tied 0 otherwise)
cnt_clr  in  1  synchronous clear of match_cnt

Behaviour:
- Reset (async, rst_n low): clears history and fill count; pattern/len/overlap take DEF_* values. Outputs: z=0, cfg_err=0, match_cnt=0.
- Registers:
  - hist[MAX_LEN-1:0]: shift register, new bit enters at bit 0.
  - fill: count of valid bits received since last clear, saturates at MAX_LEN.
  - pat, len, ovl: active configuration.
- Accepted bit (x_valid=1, cfg_load=0):
  - hist <= {hist[MAX_LEN-2:0], x}.
  - fill <= min(fill+1, MAX_LEN).
- Match condition, evaluated on next-state values: fill_next >= len AND hist_next[len-1:0] == pat[len-1:0] AND cfg_err=0.
- z output:
  - z <= match condition at the edge that samples the final pattern bit.
  - z is high for exactly one cycle per match.
  - z <= 0 on any edge with no accepted bit.
- Overlap mode:
  - ovl=1: history is retained after a match, so overlapping matches are detected (e.g. 1011011 with pattern 1011 gives 2 matches).
  - ovl=0: on a match, fill <= 0. The next match requires len fresh bits.
- x_valid=0: hist, fill and z behave as above (no bit accepted); stalls never break a partial match.
- cfg_load=1:
  - pat/len/ovl load from cfg_*.
  - hist <= 0, fill <= 0, z <= 0.
  - cfg_err <= (cfg_len==0 || cfg_len>MAX_LEN).
  - A bit presented in the same cycle is discarded (cfg_load wins).
- Illegal length: while cfg_err=1, z never asserts and bits still shift. The error clears on the next legal cfg_load.
- Pattern bits above index len-1 are ignored.
- Latency: 0 cycles from the sampling edge to z, i.e. z is valid in the cycle after the final bit is presented.
- Reset mid-pattern: all partial progress is lost; detection restarts from empty history.

Optional Feature:
- Macro: SEQ_DETECT_COUNT_EN.
- Defined:
  - match_cnt increments on every cycle where z is set.
  - Saturates at 2^CNT_W-1.
  - cnt_clr zeroes it synchronously; cnt_clr wins over a simultaneous increment.
  - cfg_load does not clear it.
- Not defined: match_cnt is constant 0, cnt_clr is ignored, and no counter flops are inferred.

Decomposition:
- Package seq_detect_pkg holds:
  - localparam LEN_W = $clog2(MAX_LEN+1) helper function.
  - Default pattern/length constants.
  - The cfg struct type {pattern, len, overlap}.
- Sub-module seq_match_counter: the saturating counter with clear, instantiated only under SEQ_DETECT_COUNT_EN.

Test Plan:
1. Defaults after reset; x_valid=1 stream 1,0,1,1,0,1,1 -> z high after bits 4 and 7 (2 pulses); match_cnt=2.
2. cfg_load pattern 1011, len 4, overlap=0; stream 1011011 -> single z after bit 4; stream 10111011 -> z after bits 4 and 8.
3. Stall: 1,0,[x_valid=0 for 3 cycles],1,1 -> z one cycle after the final 1; z=0 during stall cycles.
4. cfg_load len=8 pattern 8'hA5, overlap=1; feed A5A5 (MSB first) -> z after bits 8 and 16 only; mid-stream cfg_load at bit 5 -> no z until 8 fresh bits.
5. cfg_load cfg_len=0 -> cfg_err=1, z stays 0 for any stream; legal reload -> cfg_err=0. rst_n pulsed low mid-pattern (after 1,0,1) then 1 -> no z.
6. Counter (macro on, CNT_W=2): 5 matches -> match_cnt saturates at 3; cnt_clr coincident with match -> match_cnt=0.
